// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program-counter owner and instruction fetch front end.
// Issues word requests to instruction memory over a valid/ready channel, takes
// in-order responses into a small instruction/PC buffer and hands the buffer
// head to decode over a valid/ready handshake. A redirect flushes the buffer
// and discards responses still in flight for the old path.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (misaligned redirect halts
// fetch and raises a sticky fetch_misalign flag). When undefined, the low two
// redirect target bits are forced to zero and fetch_misalign is tied low.
module instr_fetch_unit #(
  parameter int unsigned               WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0]    RESET_PC    = '0,
  parameter int unsigned               FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WORD_LENGTH-1:0] imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [WORD_LENGTH-1:0] imem_resp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [WORD_LENGTH-1:0] instr,
  output logic [WORD_LENGTH-1:0] instr_pc,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   fetch_misalign
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned XW = CW + 1;
  localparam logic [WORD_LENGTH-1:0] NOP_INSTR = WORD_LENGTH'(32'h0000_0013);
  localparam logic [WORD_LENGTH-1:0] PC_STEP   = WORD_LENGTH'(4);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [WORD_LENGTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_LENGTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]          occ_q, occ_d;
  logic [CW-1:0]          outst_q, outst_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [WORD_LENGTH-1:0] buf_instr_q [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] buf_instr_d [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] buf_pc_q    [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] buf_pc_d    [FIFO_DEPTH];

  logic                   has_entry;
  logic                   pop;
  logic                   push;
  logic                   req_fire;
  logic [XW-1:0]          credit_used;
  logic [WORD_LENGTH-1:0] redirect_tgt;
  logic                   redirect_bad;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign redirect_tgt   = redirect_pc;
  assign redirect_bad   = |redirect_pc[1:0];
  assign fetch_misalign = misalign_q;
`else
  // Targets are word aligned by construction; the low bits are simply cleared.
  assign redirect_tgt   = redirect_pc & ~WORD_LENGTH'(3);
  assign redirect_bad   = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // A redirect suppresses both the decode handshake and new requests that cycle.
  assign has_entry   = (occ_q != '0);
  assign instr_valid = has_entry && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  // Credit counts buffered plus in-flight entries, freeing the slot popped now.
  assign credit_used = {1'b0, occ_q} + {1'b0, outst_q} - XW'(pop);
  assign imem_req_valid = (state_q == ST_FETCH) && !redirect_valid &&
                          (credit_used < XW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses are buffered only when nothing remains to discard for an old path.
  assign push           = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  assign instr    = has_entry ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
  assign instr_pc = has_entry ? buf_pc_q[rd_ptr_q]    : '0;

  // Next-state for sequencing, PCs, credit counters and the instruction buffer.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    occ_d       = occ_q + CW'(push) - CW'(pop);
    outst_d     = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d      = drop_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      buf_instr_d[wr_ptr_q] = imem_resp_data;
      buf_pc_d[wr_ptr_q]    = resp_pc_q;
      wr_ptr_d              = wr_ptr_q + PW'(1);
      resp_pc_d             = resp_pc_q + PC_STEP;
    end

    // Redirect overrides everything: flush, retarget, and mark every request
    // still outstanding after this cycle's response as stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = outst_q - CW'(imem_resp_valid);
      state_d    = redirect_bad ? ST_HALT : ST_FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_d = redirect_bad;
`endif
    end
  end

  // Control state: cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  // Sticky misaligned-target flag, updated only by redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  // Buffer storage carries data only; validity lives in occ_q, so no reset.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model and a
// scoreboard of expected {pc, instruction} pairs consumed at decode.
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_misalign;

  instr_fetch_unit #(
    .WORD_LENGTH(32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_pipe [$];
  logic [31:0] exp_q [$];
  logic [31:0] exp_fetch_pc = RST_PC;
  bit          mem_stall = 0;
  bit          chk_credit = 0;
  bit          popped;
  int          pops = 0;
  logic [31:0] last_pop_pc;
  logic        obs_req_valid, obs_instr_valid, obs_misalign;
  logic [31:0] obs_instr, obs_instr_pc;

  // Memory contents: a simple address-dependent pattern that is never a NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 4) ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef IFETCH_MISALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: observe mid-cycle, score pops and accepts, then drive memory.
  task automatic tick();
    logic [31:0] a;
    @(negedge clk);
    popped          = 0;
    obs_req_valid   = imem_req_valid;
    obs_instr_valid = instr_valid;
    obs_instr       = instr;
    obs_instr_pc    = instr_pc;
    obs_misalign    = fetch_misalign;
    if (redirect_valid) begin
      chk("redir_no_req", 32'(imem_req_valid), 0);
      chk("redir_no_instr", 32'(instr_valid), 0);
      exp_q.delete();
      exp_fetch_pc = tgt(redirect_pc);
    end else begin
      if (instr_valid && instr_ready) begin
        chk("pop_has_expect", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          a = exp_q.pop_front();
          chk("pop_pc", instr_pc, a);
          chk("pop_instr", instr, mem_word(a));
        end
        popped      = 1;
        pops++;
        last_pop_pc = instr_pc;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_fetch_pc);
        mem_pipe.push_back(imem_req_addr);
        exp_q.push_back(exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (chk_credit) chk("credit", 32'(exp_q.size() <= DEPTH), 1);
    end
    @(posedge clk);
    #1;
    if (!mem_stall && mem_pipe.size() > 0) begin
      a = mem_pipe.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(a);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic expect_first_pop(input string tag, input logic [31:0] pc);
    int n = 0;
    popped = 0;
    while (!popped && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(popped), 1);
    chk(tag, last_pop_pc, pc);
  endtask

  // Release reset and measure cycles to first request and first valid instruction.
  task automatic startup(input string tag);
    int first_req = -1;
    int first_vld = -1;
    logic [31:0] first_pc = '1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_req_valid && first_req < 0) first_req = i;
      if (obs_instr_valid && first_vld < 0) begin
        first_vld = i;
        first_pc  = obs_instr_pc;
      end
    end
    chk({tag, "_first_req_cycle"}, 32'(first_req), 1);
    chk({tag, "_first_valid_cycle"}, 32'(first_vld), 3);
    chk({tag, "_first_pc"}, first_pc, RST_PC);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_misalign"}, 32'(fetch_misalign), 0);
  endtask

  initial begin
    // Reset held from time zero.
    tick();
    tick();
    check_reset_outputs("rst");

    // Startup latency and steady streaming from RESET_PC.
    startup("boot");
    pops = 0;
    repeat (20) tick();
    chk("throughput_pops", 32'(pops), 20);

    // Decode back-pressure: credit limits fetch, order preserved on release.
    instr_ready = 1'b0;
    chk_credit  = 1;
    repeat (5) tick();
    chk("stall_req_valid", 32'(obs_req_valid), 0);
    chk("stall_instr_valid", 32'(obs_instr_valid), 1);
    chk_credit  = 0;
    instr_ready = 1'b1;
    repeat (8) tick();

    // Redirect with two requests stuck in memory: both responses are stale.
    mem_stall = 1;
    repeat (4) tick();
    chk("inflight_req_blocked", 32'(obs_req_valid), 0);
    redirect(32'h0000_0100);
    mem_stall = 0;
    tick();
    chk("post_redir_valid", 32'(obs_instr_valid), 0);
    chk("post_redir_instr", obs_instr, NOP);
    chk("post_redir_pc", obs_instr_pc, 32'h0);
    expect_first_pop("redir_inflight_pc", 32'h0000_0100);
    repeat (6) tick();

    // Redirect while a response arrives and decode is popping.
    redirect(32'h0000_0300);
    tick();
    chk("stream_redir_valid", 32'(obs_instr_valid), 0);
    expect_first_pop("redir_stream_pc", 32'h0000_0300);
    repeat (6) tick();

    // Misaligned redirect target.
    redirect(32'h0000_0102);
`ifdef IFETCH_MISALIGN_CHECK_EN
    tick();
    chk("halt_misalign", 32'(obs_misalign), 1);
    repeat (4) tick();
    chk("halt_no_req", 32'(obs_req_valid), 0);
    chk("halt_misalign_sticky", 32'(obs_misalign), 1);
    redirect(32'h0000_0200);
    tick();
    chk("resume_misalign_clear", 32'(obs_misalign), 0);
    expect_first_pop("resume_pc", 32'h0000_0200);
`else
    tick();
    chk("misalign_tied_low", 32'(obs_misalign), 0);
    expect_first_pop("aligned_target_pc", 32'h0000_0100);
`endif
    repeat (6) tick();

    // Asynchronous reset with the buffer full, then restart at RESET_PC.
    instr_ready = 1'b0;
    repeat (5) tick();
    chk("pre_reset_full", 32'(obs_instr_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    mem_pipe.delete();
    exp_q.delete();
    exp_fetch_pc    = RST_PC;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    instr_ready     = 1'b1;
    tick();
    tick();
    startup("restart");
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
